// File: rtl/regfile_write_sequencer.sv
// Serialises the E/M writeback pair onto one register-file write port through an
// in-order queue, with newest-wins read bypass over the entries still pending.
module regfile_write_sequencer #(
   parameter int         DEPTH = 4,
   parameter logic [3:0] RNONE = 4'hF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  dstE,
   input  logic [63:0] valE,
   input  logic [3:0]  dstM,
   input  logic [63:0] valM,
   output logic        wr_en,
   output logic [3:0]  wr_addr,
   output logic [63:0] wr_data,
   input  logic [3:0]  srcA,
   input  logic [3:0]  srcB,
   output logic        fwdA_hit,
   output logic [63:0] fwdA_val,
   output logic        fwdB_hit,
   output logic [63:0] fwdB_val,
   output logic        drained
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [3:0]       addr_q [DEPTH];
   logic [63:0]      data_q [DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic             accept;
   logic             enq_e;
   logic             enq_m;
   logic             pop;
   logic [PTR_W-1:0] m_slot;

   // Ready only when a worst-case pair fits; a same-cycle pop earns no credit.
   assign in_ready = (count_q <= CNT_W'(DEPTH - 2));
   assign accept   = in_valid & in_ready;
   assign enq_e    = accept & (dstE != RNONE);
   assign enq_m    = accept & (dstM != RNONE);
   assign pop      = (count_q != '0);
   assign m_slot   = enq_e ? tail_q + PTR_W'(1) : tail_q;

   assign head_d  = head_q + PTR_W'(pop);
   assign tail_d  = tail_q + PTR_W'(enq_e) + PTR_W'(enq_m);
   assign count_d = count_q + CNT_W'(enq_e) + CNT_W'(enq_m) - CNT_W'(pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (enq_e) begin
         addr_q[tail_q] <= dstE;
         data_q[tail_q] <= valE;
      end
      if (enq_m) begin
         addr_q[m_slot] <= dstM;
         data_q[m_slot] <= valM;
      end
   end

   assign wr_en   = pop;
   assign wr_addr = pop ? addr_q[head_q] : '0;
   assign wr_data = pop ? data_q[head_q] : '0;
   assign drained = ~pop;

   // Scan oldest to newest so a later match overrides an earlier one.
   always_comb begin
      logic [PTR_W-1:0] idx;
      fwdA_hit = 1'b0;
      fwdA_val = '0;
      fwdB_hit = 1'b0;
      fwdB_val = '0;
      idx      = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head_q + PTR_W'(i);
         if (CNT_W'(i) < count_q) begin
            if ((srcA != RNONE) && (addr_q[idx] == srcA)) begin
               fwdA_hit = 1'b1;
               fwdA_val = data_q[idx];
            end
            if ((srcB != RNONE) && (addr_q[idx] == srcB)) begin
               fwdB_hit = 1'b1;
               fwdB_val = data_q[idx];
            end
         end
      end
   end

endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Directed bench for regfile_write_sequencer: reset, ordering, bypass,
// backpressure against a small in-order model, and mid-operation reset.
module tb_regfile_write_sequencer;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  dstE;
   logic [63:0] valE;
   logic [3:0]  dstM;
   logic [63:0] valM;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [63:0] wr_data;
   logic [3:0]  srcA;
   logic [3:0]  srcB;
   logic        fwdA_hit;
   logic [63:0] fwdA_val;
   logic        fwdB_hit;
   logic [63:0] fwdB_val;
   logic        drained;

   int n_checks = 0;
   int n_fail   = 0;

   regfile_write_sequencer #(.DEPTH(4), .RNONE(4'hF)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .dstE     (dstE),
      .valE     (valE),
      .dstM     (dstM),
      .valM     (valM),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .srcA     (srcA),
      .srcB     (srcB),
      .fwdA_hit (fwdA_hit),
      .fwdA_val (fwdA_val),
      .fwdB_hit (fwdB_hit),
      .fwdB_val (fwdB_val),
      .drained  (drained)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_pair(input logic [3:0] de, input logic [63:0] ve,
                             input logic [3:0] dm, input logic [63:0] vm);
      in_valid = 1'b1;
      dstE     = de;
      valE     = ve;
      dstM     = dm;
      valM     = vm;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      dstE     = 4'hF;
      dstM     = 4'hF;
      valE     = '0;
      valM     = '0;
   endtask

   logic [3:0]  exp_a [$];
   logic [63:0] exp_d [$];

   initial begin
      int k;
      int cycles;
      int writes;
      int peak;
      logic exp_ready;

      reset = 1'b1;
      idle();
      srcA = 4'h3;
      srcB = 4'hF;

      // 1: reset
      tick();
      tick();
      reset = 1'b0;
      check("rst_wr_en",    64'(wr_en),    64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_drained",  64'(drained),  64'd1);
      check("rst_fwdA_hit", 64'(fwdA_hit), 64'd0);
      check("rst_fwdA_val", fwdA_val,      64'd0);
      check("rst_fwdB_hit", 64'(fwdB_hit), 64'd0);

      // 2: single E write; incoming dst not visible to bypass
      drive_pair(4'h3, 64'h10, 4'hF, 64'h0);
      check("single_no_early_fwd", 64'(fwdA_hit), 64'd0);
      tick();
      idle();
      check("single_wr_en",   64'(wr_en),    64'd1);
      check("single_wr_addr", 64'(wr_addr),  64'd3);
      check("single_wr_data", wr_data,       64'h10);
      check("single_fwdA",    64'(fwdA_hit), 64'd1);
      check("single_fwdA_v",  fwdA_val,      64'h10);
      check("single_drained", 64'(drained),  64'd0);
      check("single_rnoneB",  64'(fwdB_hit), 64'd0);
      tick();
      check("single_wr_en2",   64'(wr_en),    64'd0);
      check("single_drained2", 64'(drained),  64'd1);
      check("single_fwdA2",    64'(fwdA_hit), 64'd0);

      // 3: pair ordering
      drive_pair(4'h2, 64'hA, 4'h5, 64'hB);
      tick();
      idle();
      check("pair_addr0", 64'(wr_addr), 64'd2);
      check("pair_data0", wr_data,      64'hA);
      tick();
      check("pair_en1",   64'(wr_en),   64'd1);
      check("pair_addr1", 64'(wr_addr), 64'd5);
      check("pair_data1", wr_data,      64'hB);
      tick();
      check("pair_en2",   64'(wr_en),   64'd0);

      // 4: same destination, M newer wins bypass
      srcA = 4'h4;
      srcB = 4'h4;
      drive_pair(4'h4, 64'h1, 4'h4, 64'h2);
      tick();
      idle();
      check("same_fwdA0", fwdA_val,      64'h2);
      check("same_fwdB0", fwdB_val,      64'h2);
      check("same_addr0", 64'(wr_addr),  64'd4);
      check("same_data0", wr_data,       64'h1);
      tick();
      check("same_fwdA1", fwdA_val,      64'h2);
      check("same_data1", wr_data,       64'h2);
      tick();
      check("same_hit2",  64'(fwdA_hit), 64'd0);
      check("same_hitB2", 64'(fwdB_hit), 64'd0);
      srcA = 4'hF;
      srcB = 4'hF;

      // 5: backpressure with in_valid held, checked against an in-order model
      k      = 0;
      cycles = 0;
      writes = 0;
      peak   = 0;
      while ((k < 6 || exp_a.size() != 0) && cycles < 100) begin
         exp_ready = (exp_a.size() <= 2);
         check("bp_in_ready", 64'(in_ready), 64'(exp_ready));
         check("bp_drained",  64'(drained),  64'(exp_a.size() == 0));
         if (exp_a.size() != 0) begin
            check("bp_wr_en",   64'(wr_en),   64'd1);
            check("bp_wr_addr", 64'(wr_addr), 64'(exp_a[0]));
            check("bp_wr_data", wr_data,      exp_d[0]);
            void'(exp_a.pop_front());
            void'(exp_d.pop_front());
            writes++;
         end else begin
            check("bp_wr_en_idle", 64'(wr_en), 64'd0);
         end
         if (k < 6) begin
            drive_pair(4'(1 + k), 64'h100 + 64'(k), 4'(9 + k), 64'h200 + 64'(k));
            if (exp_ready) begin
               exp_a.push_back(4'(1 + k));
               exp_d.push_back(64'h100 + 64'(k));
               exp_a.push_back(4'(9 + k));
               exp_d.push_back(64'h200 + 64'(k));
               k++;
            end
         end else begin
            idle();
         end
         if (exp_a.size() > peak) peak = exp_a.size();
         tick();
         cycles++;
      end
      idle();
      if (cycles >= 100) check("bp_timeout", 64'd1, 64'd0);
      check("bp_writes",  64'(writes), 64'd12);
      check("bp_peak",    64'(peak),   64'd3);
      check("bp_end_en",  64'(wr_en),  64'd0);

      // 6: reset with three entries pending
      drive_pair(4'h1, 64'h11, 4'h2, 64'h22);
      tick();
      drive_pair(4'h3, 64'h33, 4'h4, 64'h44);
      check("rst6_ready2", 64'(in_ready), 64'd1);
      tick();
      idle();
      check("rst6_ready3", 64'(in_ready), 64'd0);
      check("rst6_en3",    64'(wr_en),    64'd1);
      check("rst6_addr3",  64'(wr_addr),  64'd2);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rst6_en",      64'(wr_en),    64'd0);
      check("rst6_drained", 64'(drained),  64'd1);
      check("rst6_ready",   64'(in_ready), 64'd1);
      for (int c = 0; c < 3; c++) begin
         tick();
         check("rst6_no_write", 64'(wr_en), 64'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
